imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written. It SHALL be word-aligned.
REQ-003 Port clk, input, 1: sole clock. All logic is rising-edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: one-cycle request to begin a new load.
REQ-006 Port rx_valid, input, 1: a byte is offered on rx_data.
REQ-007 Port rx_data, input, 8: byte stream carrying the load image.
REQ-008 Port rx_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 Port mem_we, output, 1: write strobe to the instruction memory write port.
REQ-010 Port mem_addr, output, 32: byte address of the write. The memory indexes it as addr[31:2].
REQ-011 Port mem_wdata, output, 32: instruction word to write.
REQ-012 Port busy, output, 1: a load is in progress.
REQ-013 Port done, output, 1: the last load completed and its checksum matched.
REQ-014 Port err, output, 1: the last load failed.
REQ-015 Port cpu_rst, output, 1: active-low reset driven to the core. It SHALL be high only in state DONE.

Function
REQ-016 A byte SHALL be accepted on a cycle where rx_valid and rx_ready are both 1.
REQ-017 The image format SHALL be: LEN_LO, LEN_HI (16-bit word count N), then N×4 data bytes in little-endian order per word, then one CSUM byte.
REQ-018 The FSM SHALL have the states IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-019 IDLE/DONE/ERR -> LEN0 when start=1. On this transition the word counter, byte counter and checksum SHALL be cleared, and done and err SHALL be cleared.
REQ-020 LEN0 -> LEN1 on accept; LEN_LO is stored.
REQ-021 LEN1 transitions on accept:
- N > MAX_WORDS -> ERR.
- N = 0 -> CSUM.
- Otherwise -> DATA.
REQ-022 In DATA:
- Bytes SHALL be shifted into a word assembly register; the first byte is the least significant.
- Each accepted byte SHALL be XORed into the running checksum.
REQ-023 The memory write SHALL occur on the cycle after the 4th byte of a word is accepted:
- mem_we=1 for exactly one cycle.
- mem_addr = BASE_ADDR + 4×k, where k is the word index, 0-based.
- mem_wdata = the assembled word.
REQ-024 DATA -> CSUM on acceptance of the final data byte. The final write SHALL still issue on the following cycle.
REQ-025 CSUM transitions on accept:
- Byte equals the running checksum -> DONE.
- Otherwise -> ERR.
- For N=0 the expected CSUM value is 8'h00.
REQ-026 rx_ready SHALL be 1 in LEN0, LEN1, DATA and CSUM, and 0 in IDLE, DONE and ERR.
REQ-027 rx_ready SHALL be 0 on the cycle mem_we=1, so at most one write is pending at any time.
REQ-028 busy SHALL be 1 in LEN0, LEN1, DATA and CSUM. done SHALL be 1 only in DONE. err SHALL be 1 only in ERR.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 Words already written before an ERR SHALL NOT be rolled back.
REQ-031 rx_data SHALL be ignored whenever rx_valid=0, and on all cycles where rx_ready=0.
REQ-032 mem_addr and mem_wdata SHALL hold their last values while mem_we=0.
REQ-033 The word counter SHALL be at least 16 bits wide. It never exceeds MAX_WORDS, so no address wrap can occur.

Reset
REQ-034 rst=0 SHALL asynchronously force the following, regardless of the current state:
- state=IDLE;
- rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0;
- busy=0, done=0, err=0, cpu_rst=0;
- all counters and the checksum = 0.
REQ-035 Reset asserted in the middle of a load SHALL abort the load, and no further writes SHALL issue.
REQ-036 After rst returns high, the loader SHALL remain in IDLE until start.

Verification
REQ-037 Bench scenario: start, then bytes 02 00 | 33 E2 62 00 | 03 A3 C4 FF | CSUM=XOR of the 8 data bytes. Required response:
- Writes (addr 0, 0x0062E233) and (addr 4, 0xFFC4A303).
- done=1, cpu_rst=1.
REQ-038 Bench scenario: the same image with CSUM bit 0 flipped. Required response:
- Both writes occur.
- err=1, done=0, cpu_rst stays 0.
REQ-039 Bench scenario: LEN=0x0401 with MAX_WORDS=1024. Required response:
- ERR after LEN_HI, with no writes.
- rx_ready=0 in ERR.
REQ-040 Bench scenario: LEN=0 then CSUM=00. Required response: DONE with no writes.
REQ-041 Bench scenario: rx_valid toggled randomly during a 3-word load, and start pulsed while busy. Required response:
- Identical writes.
- The start pulse is ignored.
- mem_we never high on two consecutive cycles.
REQ-042 Bench scenario: rst pulsed low after the 6th data byte. Required response:
- All outputs return to their reset values immediately.
- Only word 0 was written.
- A subsequent start plus a full image loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses LEN_LO, LEN_HI, N little-endian words and an XOR checksum,
// writes each word to instruction memory and releases the core reset only after a clean load.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_reg, state_next;
    logic [7:0]  len_lo_reg, len_lo_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] word_cnt_reg, word_cnt_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]  csum_reg, csum_next;
    logic [23:0] word_reg, word_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;

    logic        in_load;
    logic        accept;
    logic [15:0] len_rx;
    logic        last_byte;
    logic        last_word;

    assign in_load   = (state_reg == LEN0) || (state_reg == LEN1) ||
                       (state_reg == DATA) || (state_reg == CSUM);
    // Stalling the stream during the write cycle keeps at most one write in flight.
    assign rx_ready  = in_load && !mem_we_reg;
    assign accept    = rx_valid && rx_ready;
    assign len_rx    = {rx_data, len_lo_reg};
    assign last_byte = (byte_cnt_reg == 2'd3);
    assign last_word = (({1'b0, word_cnt_reg} + 17'd1) == {1'b0, len_reg});

    assign busy      = in_load;
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == ERR);
    assign cpu_rst   = (state_reg == DONE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            len_lo_reg    <= 8'd0;
            len_reg       <= 16'd0;
            word_cnt_reg  <= 16'd0;
            byte_cnt_reg  <= 2'd0;
            csum_reg      <= 8'd0;
            word_reg      <= 24'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            len_lo_reg    <= len_lo_next;
            len_reg       <= len_next;
            word_cnt_reg  <= word_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            csum_reg      <= csum_next;
            word_reg      <= word_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_lo_next    = len_lo_reg;
        len_next       = len_reg;
        word_cnt_next  = word_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        csum_next      = csum_reg;
        word_next      = word_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next    = LEN0;
                    len_lo_next   = 8'd0;
                    len_next      = 16'd0;
                    word_cnt_next = 16'd0;
                    byte_cnt_next = 2'd0;
                    csum_next     = 8'd0;
                    word_next     = 24'd0;
                end
            end
            LEN0: begin
                if (accept) begin
                    len_lo_next = rx_data;
                    state_next  = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_next = len_rx;
                    if ({1'b0, len_rx} > MAX_LEN)
                        state_next = ERR;
                    else if (len_rx == 16'd0)
                        state_next = CSUM;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    // Right shift so the first byte of each word ends up least significant.
                    word_next     = {rx_data, word_reg[23:8]};
                    csum_next     = csum_reg ^ rx_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (last_byte) begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = BASE_ADDR + {14'd0, word_cnt_reg, 2'b00};
                        mem_wdata_next = {rx_data, word_reg};
                        word_cnt_next  = word_cnt_reg + 16'd1;
                        if (last_word)
                            state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept)
                    state_next = (rx_data == csum_reg) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
